// File: rtl/cpu_pkg.sv
// cpu_pkg: data-memory geometry and read-return owner type shared by DM and its arbiter
package cpu_pkg;
  localparam int DM_ADDR_W = 16;
  localparam int DM_DATA_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} rd_own_t;
endpackage

// File: rtl/dm_arb_starve_cnt.sv
// dm_arb_starve_cnt: saturating DMA wait counter raising force_dma once the DMA has waited MAX_WAIT cycles
module dm_arb_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);
  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] MAX = W'(MAX_WAIT);
  logic [W-1:0] wait_cnt;
  always_ff @(posedge clk)
    if (rst || !dma_req || dma_gnt) wait_cnt <= '0;
    else if (wait_cnt != MAX) wait_cnt <= wait_cnt + W'(1);
  assign force_dma = dma_req & (wait_cnt == MAX);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU-priority sharing of the data memory with a DMA port; DM_ARB_STARVE_GUARD_EN adds a DMA starvation guard
module dm_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic cpu_act, force_dma, cpu_win, dma_win;
  rd_own_t rd_own_q;
  assign cpu_act = cpu_re | cpu_we;
`ifdef DM_ARB_STARVE_GUARD_EN
  dm_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .force_dma(force_dma)
  );
`else
  assign force_dma = 1'b0;
`endif
  assign cpu_win   = !rst & cpu_act & !force_dma;
  assign dma_win   = !rst & dma_req & (!cpu_act | force_dma);
  assign dma_gnt   = dma_win;
  assign cpu_stall = !rst & cpu_act & force_dma;
  // a simultaneous load+store is issued as a store
  assign mem_we    = cpu_win ? cpu_we : dma_win & dma_we;
  assign mem_re    = cpu_win ? cpu_re & !cpu_we : dma_win & !dma_we;
  assign mem_addr  = cpu_win ? cpu_addr : dma_addr;
  assign mem_wdata = cpu_win ? cpu_wdata : dma_wdata;
  always_ff @(posedge clk)
    rd_own_q <= rst ? OWN_NONE : (mem_re ? (cpu_win ? OWN_CPU : OWN_DMA) : OWN_NONE);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  // gating with rst drops a read granted just before reset
  assign dma_rvalid = !rst & (rd_own_q == OWN_DMA);
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed checks of dm_arbiter against a cycle-level behavioural model
module tb_dm_arbiter;
  localparam int MAX_WAIT = 8;
`ifdef DM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_re = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, dma_gnt, dma_rvalid, mem_re, mem_we;
  always #5 clk = ~clk;
  dm_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  function automatic logic [15:0] seed(int i);
    return (i == 16) ? 16'hBEEF : (16'(i * 40503) ^ 16'h5A5A);
  endfunction
  logic [15:0] mem [256];
  logic [15:0] rq;
  assign mem_rdata = rq;
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else begin
      if (mem_re) rq <= mem[mem_addr[7:0]];
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
  int checks = 0, errors = 0;
  int waited = 0, pend_own = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] pend_data = 0;
  bit m_gnt = 0, m_stall = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // one clock of the reference model: inputs are already driven just after a negedge
  task automatic step;
    bit fz, act, cg, dg, er, ew;
    logic [7:0] a;
    #1;
    act = cpu_re || cpu_we;
    fz = GUARD && !rst && dma_req && waited == MAX_WAIT;
    cg = !rst && act && !fz;
    dg = !rst && dma_req && (!act || fz);
    er = cg ? (cpu_re && !cpu_we) : (dg && !dma_we);
    ew = cg ? cpu_we : (dg && dma_we);
    check("dma_gnt", dma_gnt, dg);
    check("cpu_stall", cpu_stall, fz && act);
    check("mem_re", mem_re, er);
    check("mem_we", mem_we, ew);
    if (cg || dg) check("mem_addr", mem_addr, cg ? cpu_addr : dma_addr);
    if (ew) check("mem_wdata", mem_wdata, cg ? cpu_wdata : dma_wdata);
    check("dma_rvalid", dma_rvalid, pend_own == 2 && !rst);
    if (pend_own == 2 && !rst) check("dma_rdata", dma_rdata, pend_data);
    if (pend_own == 1 && !rst) check("cpu_rdata", cpu_rdata, pend_data);
    a = cg ? cpu_addr[7:0] : dma_addr[7:0];
    m_gnt = dg;
    m_stall = fz && act;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
      pend_own = 0;
      waited = 0;
    end else begin
      pend_own = er ? (cg ? 1 : 2) : 0;
      if (er) pend_data = ref_mem[a];
      if (ew) ref_mem[a] = cg ? cpu_wdata : dma_wdata;
      waited = (dma_req && !dg) ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
    end
    @(negedge clk);
  endtask
  initial begin
    int gcyc, nstall;
    @(negedge clk);
    cpu_re = 1; dma_req = 1;
    step; step;
    rst = 0; cpu_re = 0; dma_req = 0;
    step;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0010;
    step;
    dma_req = 0;
    check("alone_rvalid", dma_rvalid, 1);
    check("alone_rdata", dma_rdata, 16'hBEEF);
    step;
    cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0030; dma_wdata = 16'h5678;
    #1 check("col_gnt", dma_gnt, 0);
    check("col_addr", mem_addr, 16'h0020);
    step;
    cpu_we = 0;
    #1 check("col_gnt2", dma_gnt, 1);
    step;
    dma_req = 0; cpu_re = 1; cpu_addr = 16'h0030;
    step;
    check("col_rd30", cpu_rdata, 16'h5678);
    cpu_addr = 16'h0020;
    step;
    check("col_rd20", cpu_rdata, 16'h1234);
    cpu_re = 0;
    step;
    dma_we = 0;
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_addr = 16'h0100 + 16'(i);
      #1 check("burst_gnt", dma_gnt, 1);
      if (i > 0) check("burst_rvalid", dma_rvalid, 1);
      step;
    end
    dma_req = 0;
    step;
    gcyc = 0; nstall = 0;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0044; cpu_re = 1;
    for (int c = 1; c <= 50; c++) begin
      if (!m_stall) cpu_addr = 16'($urandom_range(0, 255));
      step;
      if (m_stall) nstall++;
      if (m_gnt && gcyc == 0) begin
        gcyc = c;
        dma_req = 0;
      end
    end
    check("starve_gnt_cyc", gcyc, GUARD ? 9 : 0);
    check("starve_stalls", nstall, GUARD ? 1 : 0);
    cpu_re = 0; dma_req = 0;
    step;
    dma_req = 1; dma_addr = 16'h0010;
    step;
    dma_req = 0; rst = 1;
    #1 check("rst_rvalid", dma_rvalid, 0);
    check("rst_mem_re", mem_re, 0);
    step;
    rst = 0; dma_req = 1;
    #1 check("post_rst_gnt", dma_gnt, 1);
    step;
    dma_req = 0;
    step;
    for (int c = 0; c < 800; c++) begin
      if (!m_stall) begin
        cpu_re = ((c / 100) % 2 == 1) ? ($urandom % 10 != 0) : ($urandom % 3 == 0);
        cpu_we = ($urandom % 4 == 0);
        cpu_addr = 16'($urandom_range(0, 255));
        cpu_wdata = 16'($urandom);
      end
      if (!dma_req || m_gnt) begin
        dma_req = ($urandom % 2 == 0);
        dma_we = ($urandom % 2 == 0);
        dma_addr = 16'($urandom_range(0, 255));
        dma_wdata = 16'($urandom);
      end
      rst = ($urandom % 150 == 0);
      step;
    end
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between the CPU's EX_DM-stage load/store port and a DMA requester (image/pixel loader).
- The CPU has strict priority. The DMA port uses a req/gnt handshake, and its read data is returned one cycle after grant.
- Sits between the CPU data-memory port and the DM instance. It exports a stall to freeze the pipeline when the CPU is denied.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MAX_WAIT, 8, DMA wait-cycle threshold for the starvation guard (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_re  in  1  CPU load request this cycle
- cpu_we  in  1  CPU store request this cycle
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, valid one cycle after a granted load
- cpu_stall  out  1  CPU access denied this cycle; pipeline must hold EX_DM
- dma_req  in  1  DMA request; held with fields stable until granted
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA transfer accepted this cycle
- dma_rvalid  out  1  DMA read data valid (one cycle after a granted read)
- dma_rdata  out  DATA_W  DMA read data
- mem_re  out  1  to DM read enable
- mem_we  out  1  to DM write enable
- mem_addr  out  ADDR_W  to DM address
- mem_wdata  out  DATA_W  to DM write data
- mem_rdata  in  DATA_W  from DM; synchronous read, 1-cycle latency

Behaviour:
- cpu_act = cpu_re | cpu_we. If both cpu_re and cpu_we are set, the access is treated as a write (mem_re=0).
- Arbitration is combinational and per cycle. Winner is CPU if cpu_act and not forced; else DMA if dma_req; else none.
- A transfer completes on the edge where dma_req & dma_gnt are both high.
- mem_* outputs:
  - Driven from the winner's fields.
  - mem_re = mem_we = 0 when there is no winner or rst=1.
  - mem_addr and mem_wdata are don't-care when idle.
- Read-return tracking uses register rd_own_q, one of NONE/CPU/DMA:
  - Loaded each cycle with the owner of a granted read, else NONE.
  - cpu_rdata = mem_rdata unconditionally.
  - dma_rvalid = (rd_own_q==DMA); dma_rdata = mem_rdata.
- Wait counter wait_cnt, width clog2(MAX_WAIT+1):
  - Increments while dma_req & !dma_gnt, saturating at MAX_WAIT.
  - Cleared on dma_gnt or when !dma_req.
- Reset values: rd_own_q=NONE, wait_cnt=0. During rst, dma_gnt=0, cpu_stall=0, mem_re/mem_we=0, and dma_rvalid=0 from the next cycle.
- Reset mid-operation: a read granted in the cycle before rst is dropped (no dma_rvalid).
- Simultaneous CPU and DMA request with no force: CPU wins, dma_gnt=0, cpu_stall=0.
- Back-to-back DMA grants are allowed every idle-CPU cycle. Throughput is one access per cycle.

Optional Feature:
- Macro: DM_ARB_STARVE_GUARD_EN.
- Defined: force = dma_req & (wait_cnt==MAX_WAIT).
  - When force is high, the DMA wins. cpu_stall = cpu_act, and no CPU access is issued.
  - The CPU retries next cycle with its fields held by the stalled pipeline.
  - After the forced grant wait_cnt clears, so the CPU wins again. At most one forced DMA beat occurs per MAX_WAIT denied cycles.
- Undefined: force = 0, and cpu_stall is tied to 0. This is strict CPU priority, and a DMA may starve indefinitely.

Decomposition:
- Shared package (cpu_pkg):
  - rd_own_t enum {OWN_NONE, OWN_CPU, OWN_DMA}.
  - DM_ADDR_W and DM_DATA_W constants, reused by DM and this block.
- Natural sub-module: dm_arb_starve_cnt, the saturating wait counter plus force compare, instantiated only under the macro.

Test Plan:
- DMA alone:
  - Stimulus: dma_req=1, dma_we=0, dma_addr=0x0010, memory[0x0010]=0xBEEF.
  - Required: dma_gnt=1 and mem_re=1 in cycle N; dma_rvalid=1 and dma_rdata=0xBEEF in cycle N+1.
- CPU vs DMA collision:
  - Stimulus: cpu_we=1 at addr 0x0020, data 0x1234, simultaneously with a DMA write to 0x0030.
  - Required: mem_we with addr 0x0020 first and dma_gnt=0; DMA is granted the next cycle when the CPU is idle; memory[0x0030] is written after.
- Streaming DMA: a 4-beat read burst at 0x0100–0x0103 with the CPU idle gives 4 consecutive gnts, then 4 consecutive rvalids, with data in order.
- Starvation guard (macro on, MAX_WAIT=8):
  - Stimulus: CPU loads every cycle while dma_req is held.
  - Required: dma_gnt=1 and cpu_stall=1 exactly in the 9th cycle; CPU resumes the following cycle; no CPU load data is lost.
  - With the macro off, the same stimulus gives dma_gnt=0 for 50 cycles and cpu_stall=0 throughout.
- Reset mid-read: grant a DMA read in cycle N and assert rst in N+1. Required: dma_rvalid=0, mem_re=0, wait_cnt=0; normal grant resumes after rst deasserts.
